// File: rtl/dma_utils_pkg.sv
// Shared DMA types: streamer request/response payloads, burst mode and AXI enums.
package dma_utils_pkg;

  localparam int unsigned DMA_ADDR_WIDTH = 32;
  localparam int unsigned DMA_DATA_WIDTH = 32;
  localparam int unsigned DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;

  typedef enum logic {
    DMA_MODE_FIXED = 1'b0,
    DMA_MODE_INCR  = 1'b1
  } dma_mode_t;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef struct packed {
    logic                      valid;
    logic [DMA_ADDR_WIDTH-1:0] addr;
    logic [7:0]                alen;
    logic [2:0]                size;
    logic [DMA_STRB_WIDTH-1:0] strb;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
    logic error;
  } s_dma_axi_resp_t;

  function automatic axi_burst_t dma_mode_to_burst(input dma_mode_t mode);
    return (mode == DMA_MODE_INCR) ? AXI_BURST_INCR : AXI_BURST_FIXED;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; DEPTH must be a power of two >= 2.
module dma_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_c, pop_c;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_c  = push_i && !full_o;
  assign pop_c   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible behind valid pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dma_axi_rd_if.sv
// AXI read-channel front end for the DMA: issues AR bursts from streamer requests,
// tracks outstanding bursts and buffers R data towards the write side.
module dma_axi_rd_if
  import dma_utils_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  s_dma_axi_req_t            dma_axi_req_i,
  output s_dma_axi_resp_t           dma_axi_resp_o,
  input  dma_mode_t                 dma_mode_i,
  input  logic                      dma_abort_i,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [DMA_ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]                arlen_o,
  output logic [2:0]                arsize_o,
  output logic [1:0]                arburst_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [DMA_DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [DMA_DATA_WIDTH-1:0] rd_data_o,
  output logic                      err_o,
  input  logic                      err_clr_i,
  output logic                      idle_o
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic                      arvalid_q, arvalid_d;
  logic [DMA_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [2:0]                ar_size_q, ar_size_d;
  logic [1:0]                ar_burst_q, ar_burst_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
  logic                      err_q, err_d;

  logic ready_c, req_acc_c, ar_hs_c, r_hs_c, r_last_hs_c, r_err_c;
  logic fifo_full, fifo_empty;
  logic unused_strb;

  assign unused_strb = ^dma_axi_req_i.strb;

  // Pending AR counts against the limit so an accepted request can never overshoot it.
  assign ready_c = !dma_abort_i
                && ((SUM_W'(out_cnt_q) + SUM_W'(arvalid_q)) < SUM_W'(OUTSTANDING))
                && (!arvalid_q || arready_i);

  assign req_acc_c   = dma_axi_req_i.valid && ready_c;
  assign ar_hs_c     = arvalid_q && arready_i;
  assign r_hs_c      = rvalid_i && rready_o;
  assign r_last_hs_c = r_hs_c && rlast_i;
  assign r_err_c     = r_hs_c && ((rresp_i == AXI_SLVERR) || (rresp_i == AXI_DECERR));

  always_comb begin
    arvalid_d  = arvalid_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    if (req_acc_c) begin
      arvalid_d  = 1'b1;
      ar_addr_d  = dma_axi_req_i.addr;
      ar_len_d   = dma_axi_req_i.alen;
      ar_size_d  = dma_axi_req_i.size;
      ar_burst_d = dma_mode_to_burst(dma_mode_i);
    end else if (ar_hs_c) begin
      arvalid_d = 1'b0;
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (ar_hs_c && !r_last_hs_c) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!ar_hs_c && r_last_hs_c && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  // A new error outranks a clear arriving in the same cycle.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (r_err_c)   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid_q  <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      arvalid_q  <= arvalid_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
    end
  end

  dma_fifo #(
    .WIDTH (DMA_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (r_hs_c),
    .data_i  (rdata_i),
    .pop_i   (rd_ready_i),
    .data_o  (rd_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    dma_axi_resp_o       = '0;
    dma_axi_resp_o.ready = ready_c;
  end

  assign arvalid_o  = arvalid_q;
  assign araddr_o   = ar_addr_q;
  assign arlen_o    = ar_len_q;
  assign arsize_o   = ar_size_q;
  assign arburst_o  = ar_burst_q;
  assign rready_o   = !fifo_full;
  assign rd_valid_o = !fifo_empty;
  assign err_o      = err_q;
  assign idle_o     = !arvalid_q && (out_cnt_q == '0) && fifo_empty;

endmodule
